// File: rtl/pc_sequencer.sv
// Next-PC sequencer: owns the PC register and resolves SEQ/BEQ/BNE/JUMP/CALL/RET,
// with a circular return-address stack, sticky RAS flags and a redirect indicator.
module pc_sequencer #(
   parameter int              PC_W         = 32,
   parameter int              OFF_W        = 8,
   parameter int              RAS_DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
   input  logic                                 CLK,
   input  logic                                 RESET_N,
   input  logic [2:0]                           BR_OP,
   input  logic                                 ZERO,
   input  logic [OFF_W-1:0]                     OFFSET,
   input  logic                                 IBUSYWAIT,
   input  logic                                 DBUSYWAIT,
   input  logic                                 CLR_FLAGS,
   output logic [PC_W-1:0]                      PC,
   output logic                                 REDIRECT,
   output logic [$clog2(RAS_DEPTH+1)-1:0]       RAS_COUNT,
   output logic                                 RAS_OVERFLOW,
   output logic                                 RAS_UNDERFLOW
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);

   localparam logic [2:0] OP_BEQ  = 3'd1;
   localparam logic [2:0] OP_BNE  = 3'd2;
   localparam logic [2:0] OP_JUMP = 3'd3;
   localparam logic [2:0] OP_CALL = 3'd4;
   localparam logic [2:0] OP_RET  = 3'd5;

   logic [PC_W-1:0]  pc_q;
   logic             redirect_q;
   logic [CNT_W-1:0] ras_cnt_q;
   logic [PTR_W-1:0] ras_ptr_q;
   logic [PC_W-1:0]  ras_q [RAS_DEPTH];
   logic             ovf_q, unf_q;
   logic             ovf_d, unf_d;

   logic             stall_s;
   logic [PC_W-1:0]  seq_s, tgt_s, next_s, off_sh_s;
   logic [PTR_W-1:0] ptr_inc_s, ptr_dec_s;
   logic             push_s, pop_s, unf_set_s, ras_full_s;

   // Offset scaled to bytes; only the low PC_W bits matter since PC arithmetic wraps.
   if (PC_W > OFF_W + 2) begin : g_off_wide
      assign off_sh_s = {{(PC_W-OFF_W-2){OFFSET[OFF_W-1]}}, OFFSET, 2'b00};
   end else if (PC_W == OFF_W + 2) begin : g_off_exact
      assign off_sh_s = {OFFSET, 2'b00};
   end else begin : g_off_narrow
      logic unused_off_hi_s;
      assign unused_off_hi_s = ^OFFSET[OFF_W-1:PC_W-2];
      assign off_sh_s        = {OFFSET[PC_W-3:0], 2'b00};
   end

   // Next-PC selection, RAS push/pop requests and sticky flag next-state.
   always_comb begin
      stall_s    = IBUSYWAIT | DBUSYWAIT;
      seq_s      = pc_q + PC_W'(4);
      tgt_s      = seq_s + off_sh_s;
      ptr_inc_s  = ras_ptr_q + PTR_W'(1);
      ptr_dec_s  = ras_ptr_q - PTR_W'(1);
      ras_full_s = (ras_cnt_q == CNT_W'(RAS_DEPTH));
      next_s     = seq_s;
      push_s     = 1'b0;
      pop_s      = 1'b0;
      unf_set_s  = 1'b0;
      case (BR_OP)
         OP_BEQ: begin
            if (ZERO) next_s = tgt_s;
            else      next_s = seq_s;
         end
         OP_BNE: begin
            if (!ZERO) next_s = tgt_s;
            else       next_s = seq_s;
         end
         OP_JUMP: next_s = tgt_s;
         OP_CALL: begin
            next_s = tgt_s;
            push_s = 1'b1;
         end
         OP_RET: begin
            if (ras_cnt_q != CNT_W'(0)) begin
               next_s = ras_q[ras_ptr_q];
               pop_s  = 1'b1;
            end else begin
               next_s    = seq_s;
               unf_set_s = 1'b1;
            end
         end
         default: next_s = seq_s;
      endcase
      // A flag being set on this edge wins over a simultaneous clear.
      ovf_d = (ovf_q & ~CLR_FLAGS) | (~stall_s & push_s & ras_full_s);
      unf_d = (unf_q & ~CLR_FLAGS) | (~stall_s & unf_set_s);
   end

   // PC, redirect, return-address stack and flag registers.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         pc_q       <= RESET_VECTOR;
         redirect_q <= 1'b0;
         ras_cnt_q  <= '0;
         ras_ptr_q  <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            ras_q[i] <= '0;
         end
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
         if (stall_s) begin
            redirect_q <= 1'b0;
         end else begin
            pc_q       <= next_s;
            redirect_q <= (next_s != seq_s);
            if (push_s) begin
               ras_q[ptr_inc_s] <= seq_s;
               ras_ptr_q        <= ptr_inc_s;
               if (!ras_full_s) ras_cnt_q <= ras_cnt_q + CNT_W'(1);
               else             ras_cnt_q <= ras_cnt_q;
            end else if (pop_s) begin
               ras_ptr_q <= ptr_dec_s;
               ras_cnt_q <= ras_cnt_q - CNT_W'(1);
            end else begin
               ras_ptr_q <= ras_ptr_q;
            end
         end
      end
   end

   assign PC            = pc_q;
   assign REDIRECT      = redirect_q;
   assign RAS_COUNT     = ras_cnt_q;
   assign RAS_OVERFLOW  = ovf_q;
   assign RAS_UNDERFLOW = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a 32-bit instance (reset vector 0x100) and an 8-bit instance for wrap cases.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n_a, rst_n_b;
   logic [2:0]  br_op_a, br_op_b;
   logic        zero_a, zero_b;
   logic [7:0]  offset_a, offset_b;
   logic        ibusy_a, dbusy_a, clr_a;
   logic [31:0] pc_a;
   logic        redirect_a, ovf_a, unf_a;
   logic [2:0]  cnt_a;
   logic [7:0]  pc_b;
   logic        redirect_b, ovf_b, unf_b;
   logic [2:0]  cnt_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pc_sequencer #(.PC_W(32), .OFF_W(8), .RAS_DEPTH(4), .RESET_VECTOR(32'h0000_0100)) u_dut_a (
      .CLK(clk), .RESET_N(rst_n_a), .BR_OP(br_op_a), .ZERO(zero_a), .OFFSET(offset_a),
      .IBUSYWAIT(ibusy_a), .DBUSYWAIT(dbusy_a), .CLR_FLAGS(clr_a),
      .PC(pc_a), .REDIRECT(redirect_a), .RAS_COUNT(cnt_a),
      .RAS_OVERFLOW(ovf_a), .RAS_UNDERFLOW(unf_a)
   );

   pc_sequencer #(.PC_W(8), .OFF_W(8), .RAS_DEPTH(4), .RESET_VECTOR(8'h00)) u_dut_b (
      .CLK(clk), .RESET_N(rst_n_b), .BR_OP(br_op_b), .ZERO(zero_b), .OFFSET(offset_b),
      .IBUSYWAIT(1'b0), .DBUSYWAIT(1'b0), .CLR_FLAGS(1'b0),
      .PC(pc_b), .REDIRECT(redirect_b), .RAS_COUNT(cnt_b),
      .RAS_OVERFLOW(ovf_b), .RAS_UNDERFLOW(unf_b)
   );

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step_a(input logic [2:0] op, input logic [7:0] off, input logic z,
                         input logic ib, input logic db, input logic clr);
      br_op_a  = op;
      offset_a = off;
      zero_a   = z;
      ibusy_a  = ib;
      dbusy_a  = db;
      clr_a    = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic step_b(input logic [2:0] op, input logic [7:0] off);
      br_op_b  = op;
      offset_b = off;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_pc_a(input string tag, input logic [31:0] pc, input logic red);
      chk_val({tag, "_pc"}, pc_a, pc);
      chk_val({tag, "_redir"}, 32'(redirect_a), 32'(red));
   endtask

   initial begin
      rst_n_a = 1'b0; rst_n_b = 1'b0;
      br_op_a = 3'd0; offset_a = 8'h00; zero_a = 1'b0;
      ibusy_a = 1'b0; dbusy_a = 1'b0; clr_a = 1'b0;
      br_op_b = 3'd0; offset_b = 8'h00; zero_b = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n_a = 1'b1;
      chk_pc_a("rst", 32'h100, 1'b0);
      chk_val("rst_cnt", 32'(cnt_a), 32'd0);
      chk_val("rst_ovf", 32'(ovf_a), 32'd0);
      chk_val("rst_unf", 32'(unf_a), 32'd0);

      step_a(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); chk_pc_a("seq1", 32'h104, 1'b0);
      step_a(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); chk_pc_a("seq2", 32'h108, 1'b0);
      step_a(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); chk_pc_a("seq3", 32'h10C, 1'b0);

      // Asynchronous reset taking effect mid-cycle
      #3 rst_n_a = 1'b0;
      #1 chk_pc_a("async_rst", 32'h100, 1'b0);
      rst_n_a = 1'b1;

      step_a(3'd3, 8'hC7, 1'b0, 1'b0, 1'b0, 1'b0); chk_pc_a("jmp_back", 32'h20, 1'b1);
      step_a(3'd1, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0); chk_pc_a("beq_taken", 32'h1C, 1'b1);
      step_a(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); chk_pc_a("seq_20", 32'h20, 1'b0);
      step_a(3'd1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0); chk_pc_a("beq_not", 32'h24, 1'b0);
      step_a(3'd2, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0); chk_pc_a("bne_taken", 32'h34, 1'b1);
      step_a(3'd2, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0); chk_pc_a("bne_not", 32'h38, 1'b0);
      step_a(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      step_a(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); chk_pc_a("seq_40", 32'h40, 1'b0);

      for (int i = 0; i < 3; i++) begin
         step_a(3'd3, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0);
         chk_pc_a("istall", 32'h40, 1'b0);
      end
      step_a(3'd3, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0); chk_pc_a("stall_rel", 32'h54, 1'b1);
      step_a(3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0); chk_pc_a("dstall", 32'h54, 1'b0);

      step_a(3'd3, 8'hEA, 1'b0, 1'b0, 1'b0, 1'b0); chk_pc_a("jmp_zero", 32'h0, 1'b1);
      step_a(3'd4, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0); chk_pc_a("call1", 32'h20, 1'b1);
      chk_val("call1_cnt", 32'(cnt_a), 32'd1);
      step_a(3'd4, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0); chk_pc_a("call2", 32'h28, 1'b1);
      chk_val("call2_cnt", 32'(cnt_a), 32'd2);
      step_a(3'd5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); chk_pc_a("ret1", 32'h24, 1'b1);
      chk_val("ret1_cnt", 32'(cnt_a), 32'd1);
      step_a(3'd5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); chk_pc_a("ret2", 32'h4, 1'b1);
      chk_val("ret2_cnt", 32'(cnt_a), 32'd0);

      // Five calls into a 4-deep stack: pushes 0x8,0x10,0x18,0x20,0x28
      for (int i = 0; i < 5; i++) begin
         step_a(3'd4, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
         chk_pc_a("ovf_call", 32'(4 + 8 * (i + 1)), 1'b1);
         chk_val("ovf_cnt", 32'(cnt_a), (i < 4) ? 32'(i + 1) : 32'd4);
         chk_val("ovf_flag", 32'(ovf_a), (i == 4) ? 32'd1 : 32'd0);
      end
      step_a(3'd5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); chk_pc_a("ovf_ret1", 32'h28, 1'b1);
      step_a(3'd5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); chk_pc_a("ovf_ret2", 32'h20, 1'b1);
      step_a(3'd5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); chk_pc_a("ovf_ret3", 32'h18, 1'b1);
      step_a(3'd5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); chk_pc_a("ovf_ret4", 32'h10, 1'b1);
      chk_val("ovf_ret_cnt", 32'(cnt_a), 32'd0);
      chk_val("ovf_sticky", 32'(ovf_a), 32'd1);

      // Underflowing RET with a same-edge clear: set wins for UNDERFLOW, OVERFLOW clears
      step_a(3'd5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1); chk_pc_a("unf_ret", 32'h14, 1'b0);
      chk_val("unf_flag", 32'(unf_a), 32'd1);
      chk_val("clr_ovf", 32'(ovf_a), 32'd0);
      step_a(3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1); chk_pc_a("clr_stall", 32'h14, 1'b0);
      chk_val("clr_unf", 32'(unf_a), 32'd0);
      step_a(3'd4, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0); chk_pc_a("call_stall", 32'h14, 1'b0);
      chk_val("call_stall_cnt", 32'(cnt_a), 32'd0);
      step_a(3'd6, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0); chk_pc_a("op6_seq", 32'h18, 1'b0);
      chk_val("op6_cnt", 32'(cnt_a), 32'd0);

      // 8-bit PC instance: wrap and large negative offset
      rst_n_b = 1'b1;
      chk_val("b_rst", 32'(pc_b), 32'h00);
      step_b(3'd3, 8'h3E); chk_val("b_jmp_fc", 32'(pc_b), 32'hFC);
      chk_val("b_jmp_redir", 32'(redirect_b), 32'd1);
      step_b(3'd0, 8'h00); chk_val("b_wrap", 32'(pc_b), 32'h00);
      chk_val("b_wrap_redir", 32'(redirect_b), 32'd0);
      step_b(3'd3, 8'h03); chk_val("b_jmp_10", 32'(pc_b), 32'h10);
      step_b(3'd3, 8'h80); chk_val("b_jmp_neg128", 32'(pc_b), 32'h14);
      chk_val("b_neg128_redir", 32'(redirect_b), 32'd0);
      chk_val("b_flags", 32'({ovf_b, unf_b, cnt_b}), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
